fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Stores fetched {pc, instr} pairs in an in-order FIFO, so a decode stall does not immediately stall fetch.
- Discards all queued wrong-path instructions on a redirect (branch, exception or eret).
- Output is registered from the queue head. There is no combinational path from any input to any output.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- AW, $clog2(DEPTH), pointer index width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents a valid, non-bubble instruction this cycle.
- in_pc  input  32  pc of the presented instruction.
- in_instr  input  32  presented instruction word.
- in_ready  output  1  queue can accept an entry; equals !full.
- flush  input  1  redirect; discard all entries and any same-cycle push.
- out_valid  output  1  head entry valid; equals !empty.
- out_pc  output  32  pc of the head entry.
- out_instr  output  32  instruction of the head entry.
- out_ready  input  1  decode consumes the head entry (driven as !stall).
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - rd_ptr = wr_ptr = 0, count = 0.
  - out_valid = 0, in_ready = 1.
  - out_pc and out_instr = 0.
  - Storage array is not reset.
- Pointers:
  - rd_ptr and wr_ptr are AW+1 bits wide; the MSB is the wrap bit.
  - empty when the two pointers are fully equal.
  - full when the index bits are equal and the wrap bits differ.
- Handshakes:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
- Write on push: mem[wr_ptr[AW-1:0]] <= {in_pc, in_instr}; wr_ptr increments.
- Read on pop: rd_ptr increments.
- out_pc and out_instr always show mem[rd_ptr index].
  - They are stable while out_valid=1 and no pop occurs.
  - When out_valid=0 their value is don't-care.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1 (out_valid=1). There is no same-cycle bypass.
- Simultaneous push and pop, non-empty and non-full: both occur; count is unchanged.
- Full: in_ready=0, so no push. A pop in the same cycle does not enable a push; in_ready reopens the following cycle.
- Empty: out_valid=0, so out_ready is ignored.
- Flush:
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0, out_valid = 0, in_ready = 1.
  - Flush overrides a same-cycle push and pop.
  - The first post-redirect instruction may be pushed in the cycle after flush.
- count:
  - increments on push only;
  - decrements on pop only;
  - is unchanged when both or neither occur;
  - is 0 after flush.
- Wrap-around: pointers increment modulo 2·DEPTH; ordering must be preserved across any number of wraps.
- Reset asserted mid-operation: state clears immediately (asynchronous); no queued entry may appear at the output after deassertion.
- in_pc and in_instr are ignored when in_valid=0.

Test Plan:
- Single entry: reset, then push pc=0x0, instr=0xDEADBEEF with out_ready=0.
  -> Next cycle out_valid=1, out_pc=0x0, out_instr=0xDEADBEEF, count=1.
  -> Assert out_ready=1: next cycle out_valid=0, count=0.
- Fill: DEPTH=4, push pc 0x0,0x4,0x8,0xC with out_ready=0.
  -> in_ready=0 and count=4 after the 4th push.
  -> Offering pc=0x10 leaves the queue unchanged.
  -> Drain yields 0x0,0x4,0x8,0xC in order.
- Steady stream: in_valid=1 and out_ready=1 continuously for 20 cycles, pc stepping by 4 from 0x100.
  -> Outputs appear in order with 1-cycle latency.
  -> count stays at 1, and pointers wrap at least twice.
- Flush with push: 3 entries queued, then flush=1 together with in_valid=1, pc=0x200.
  -> Next cycle out_valid=0, count=0; 0x200 never appears at the output.
  -> Push 0x300 in the following cycle -> out_pc=0x300 one cycle later.
- Full with pop: at full, hold out_ready=1 and in_valid=1.
  -> First cycle: pop only, count=3.
  -> Next cycle: push and pop together, count stays 3, order preserved.
- Async reset: drop rst_n mid-cycle with 2 entries queued.
  -> out_valid=0 and count=0 before the next clock edge.
  -> After release, out_valid stays 0 until a new push.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: push side from fetch, pop side to decode,
// plus redirect flush and occupancy.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_ready;
    logic [AW:0]   count;

    // Queue side.
    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );

    // Fetch/decode side.
    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, instr} FIFO between fetch and decode with redirect flush.
// The head entry is held in a register so outputs depend only on state.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      r_mem [DEPTH];
    entry_t      r_head;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [AW:0] w_wr_next;
    logic [AW:0] w_rd_next;
    entry_t      w_head_next;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign w_push  = q.in_valid & ~w_full  & ~q.flush;
    assign w_pop   = ~w_empty & q.out_ready & ~q.flush;

    always_comb begin
        w_wr_next = r_wr_ptr;
        w_rd_next = r_rd_ptr;
        if (q.flush) begin
            w_wr_next = '0;
            w_rd_next = '0;
        end else begin
            if (w_push) w_wr_next = r_wr_ptr + PTR_ONE;
            if (w_pop)  w_rd_next = r_rd_ptr + PTR_ONE;
        end
    end

    // The next head slot may be the one being written this cycle (push into an
    // empty queue, or push+pop with one entry), so forward the incoming data.
    always_comb begin
        w_head_next = r_mem[w_rd_next[AW-1:0]];
        if (w_push && (r_wr_ptr[AW-1:0] == w_rd_next[AW-1:0])) begin
            w_head_next = {q.in_pc, q.in_instr};
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are
    // live, so resetting the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {q.in_pc, q.in_instr};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_head   <= w_head_next;
        end
    end

    assign q.in_ready  = ~w_full;
    assign q.out_valid = ~w_empty;
    assign q.out_pc    = r_head.pc;
    assign q.out_instr = r_head.instr;
    assign q.count     = r_wr_ptr - r_rd_ptr;
endmodule
